// File: rtl/distance_pkg.sv
// ============================================================================
// Module  : distance_pkg
// Brief   : Shared FSM encoding, default thresholds and widths for distance_proc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package distance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AVG  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] DEF_MAX_RANGE  = 16'd400;
  localparam logic [15:0] DEF_ALARM_NEAR = 16'd20;
  localparam logic [15:0] DEF_ALARM_FAR  = 16'd25;

  localparam int BCD_W     = 16;
  localparam int WIN_DEPTH = 4;
  localparam int SUM_W     = 18;

endpackage

`default_nettype wire

// File: rtl/distance_proc_bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : 16-bit sequential double-dabble, one bit per cycle MSB first,
//           start/done handshake; result register holds between conversions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import distance_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BCD_W-1:0] bin_i,
  output logic             last_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W-1:0]   bin_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_adj;
  logic [2*BCD_W-1:0] step_shift;
  logic [BCD_W-1:0]   result_q;
  logic [3:0]         cnt_q;
  logic               active_q;
  logic               done_q;

  // Add-3 correction on every digit >= 5, then shift the pair {bcd, bin} left.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    step_shift = {work_adj, bin_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q    <= bin_i;
        work_q   <= '0;
        cnt_q    <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        bin_q  <= step_shift[BCD_W-1:0];
        work_q <= step_shift[2*BCD_W-1:BCD_W];
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
          result_q <= step_shift[2*BCD_W-1:BCD_W];
        end
      end
    end
  end

  assign last_o = active_q && (cnt_q == 4'd15);
  assign done_o = done_q;
  assign bcd_o  = result_q;

endmodule

`default_nettype wire

// File: rtl/distance_proc.sv
// ============================================================================
// Module  : distance_proc
// Brief   : Range-checks distance samples, averages a 4-deep window and emits
//           packed BCD. Optional proximity alarm enabled by DIST_ALARM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module distance_proc
  import distance_pkg::*;
#(
  parameter logic [15:0] MAX_RANGE  = DEF_MAX_RANGE,
  parameter logic [15:0] ALARM_NEAR = DEF_ALARM_NEAR,
  parameter logic [15:0] ALARM_FAR  = DEF_ALARM_FAR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      distance_data,
  input  logic             distance_valid,
  output logic [BCD_W-1:0] bcd_data,
  output logic             bcd_valid,
  output logic             out_of_range,
  output logic             overrun,
  output logic             busy
`ifdef DIST_ALARM_EN
  ,
  output logic             alarm
`endif
);

  if (MAX_RANGE > 16'd9999 || ALARM_FAR <= ALARM_NEAR) begin : g_cfg_bad
    $error("distance_proc: illegal parameter set");
  end

  state_e                     state_q, state_d;
  logic [WIN_DEPTH-1:0][15:0] win_q;
  logic                       filled_q;
  logic                       oor_q;
  logic                       overrun_q;
  logic [SUM_W-1:0]           sum;
  logic [15:0]                avg;
  logic                       in_range;
  logic                       accept;
  logic                       reject;
  logic                       drop;
  logic                       conv_last;

  assign in_range = (distance_data != 16'd0) && (distance_data <= MAX_RANGE);
  assign sum      = SUM_W'(win_q[0]) + SUM_W'(win_q[1]) + SUM_W'(win_q[2]) + SUM_W'(win_q[3]);
  assign avg      = 16'(sum >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (distance_valid) begin
          if (in_range) begin
            accept  = 1'b1;
            state_d = ST_AVG;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_AVG:  state_d = ST_CONV;
      ST_CONV: if (conv_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Samples arriving mid-conversion are discarded without range checking.
    if (state_q != ST_IDLE) drop = distance_valid;
  end

  // The first accepted sample after reset primes the whole window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      filled_q  <= 1'b0;
      oor_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop;
      if (accept) begin
        oor_q    <= 1'b0;
        filled_q <= 1'b1;
        if (!filled_q) win_q <= {WIN_DEPTH{distance_data}};
        else           win_q <= {win_q[WIN_DEPTH-2:0], distance_data};
      end else if (reject) begin
        oor_q <= 1'b1;
      end
    end
  end

`ifdef DIST_ALARM_EN
  logic alarm_q;

  // Hysteresis: set below NEAR, clear at or above FAR, hold in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else if (state_q == ST_AVG) begin
      if (avg < ALARM_NEAR)      alarm_q <= 1'b1;
      else if (avg >= ALARM_FAR) alarm_q <= 1'b0;
    end
  end

  assign alarm = alarm_q;
`endif

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (state_q == ST_AVG),
    .bin_i   (avg),
    .last_o  (conv_last),
    .done_o  (bcd_valid),
    .bcd_o   (bcd_data)
  );

  assign out_of_range = oor_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
